rom_access_arb: RTL and testbench

- Shares the single-port synchronous ROM (x_s3e_sprom, 1-cycle registered read) between two read masters: M0 = instruction fetch, M1 = data-side bus / boot loader.
- Round-robin arbitration, one read in flight at a time, one ack pulse per read.
- Sits between the masters and the ROM macro, and drives the ROM address directly.

---
 rtl/rom_access_arb_pkg.sv | 20 ++
 rtl/rom_access_arb_if.sv | 30 +++
 rtl/rom_access_arb_rr_arb2.sv | 27 ++
 rtl/rom_access_arb.sv | 79 +++++++
 tb/tb_rom_access_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rom_access_arb_pkg.sv
// Shared constants and types for the ROM access arbiter: ROM geometry, owner ids, FSM states.
package rom_access_arb_pkg;

  localparam int ROM_ADDR_W  = 11;
  localparam int ROM_DEPTH   = 1 << ROM_ADDR_W;
  localparam int WORD_DATA_W = 32;

  localparam logic ROM_ARB_OWNER_M0 = 1'b0;
  localparam logic ROM_ARB_OWNER_M1 = 1'b1;

  typedef enum logic {
    ROM_ARB_ST_IDLE = 1'b0,
    ROM_ARB_ST_READ = 1'b1
  } rom_arb_st_e;

  function automatic logic [1:0] owner_onehot(input logic id);
    return (id == ROM_ARB_OWNER_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rom_access_arb_if.sv
// Bundle of both read-master handshakes plus the ROM address/data pins.
interface rom_access_arb_if
  import rom_access_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) ();

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rd_data;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rd_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, rom_dout,
    output m0_ack, m0_rd_data, m1_ack, m1_rd_data, rom_addr
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, rom_dout,
    input  m0_ack, m0_rd_data, m1_ack, m1_rd_data, rom_addr
  );

endinterface

// File: rtl/rom_access_arb_rr_arb2.sv
// Two-input round-robin picker, purely combinational; on a tie the requester other than last wins.
module rom_access_arb_rr_arb2
  import rom_access_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    grant_valid = |elig;
    grant_id    = ROM_ARB_OWNER_M0;
    case (elig)
      2'b01:   grant_id = ROM_ARB_OWNER_M0;
      2'b10:   grant_id = ROM_ARB_OWNER_M1;
      2'b11:   grant_id = ~last;
      default: grant_id = ROM_ARB_OWNER_M0;
    endcase
  end

endmodule

// File: rtl/rom_access_arb.sv
// Shares the 1-cycle registered ROM between two read masters, round-robin, one read in flight.
// Request seen in cycle N gets its ack in N+1; acks come from flops only.
module rom_access_arb
  import rom_access_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  rom_access_arb_if.slave bus
);

  rom_arb_st_e       state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [1:0]        mask;
  logic              grant_valid;
  logic              grant_id;
  logic              addr_sel;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] rd_data;

  // The owner's request is consumed by this cycle's ack, so it cannot be granted again now.
  assign mask = (state_q == ROM_ARB_ST_READ) ? owner_onehot(owner_q) : 2'b00;

  rom_access_arb_rr_arb2 u_rr_arb2 (
    .req         ({bus.m1_req, bus.m0_req}),
    .mask        (mask),
    .last        (rr_last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d   = ROM_ARB_ST_IDLE;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;
    if (grant_valid) begin
      state_d   = ROM_ARB_ST_READ;
      owner_d   = grant_id;
      rr_last_d = grant_id;
      m0_ack_d  = (grant_id == ROM_ARB_OWNER_M0);
      m1_ack_d  = (grant_id == ROM_ARB_OWNER_M1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ROM_ARB_ST_IDLE;
      owner_q   <= ROM_ARB_OWNER_M0;
      rr_last_q <= ROM_ARB_OWNER_M1;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
    end
  end

  // With no grant the select stays on the last owner, so the ROM address is never X.
  assign addr_sel = grant_valid ? grant_id : owner_q;
  assign addr_mux = (addr_sel == ROM_ARB_OWNER_M1) ? bus.m1_addr : bus.m0_addr;

  assign bus.rom_addr   = addr_mux;
  assign rd_data        = bus.rom_dout;
  assign bus.m0_rd_data = rd_data;
  assign bus.m1_rd_data = rd_data;
  assign bus.m0_ack     = m0_ack_q;
  assign bus.m1_ack     = m1_ack_q;

endmodule

// File: tb/tb_rom_access_arb.sv
// Directed plus random bench for rom_access_arb against a cycle-level reference model.
module tb_rom_access_arb;
  import rom_access_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  rom_access_arb_if #(.ADDR_W(ROM_ADDR_W), .DATA_W(WORD_DATA_W)) bus ();

  rom_access_arb #(.ADDR_W(ROM_ADDR_W), .DATA_W(WORD_DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM model: registered read of a preloaded array
  logic [31:0] mem [ROM_DEPTH];
  initial for (int i = 0; i < ROM_DEPTH; i++) mem[i] = 32'hA500_0000 + 32'(i);
  always @(posedge clk) bus.rom_dout <= mem[bus.rom_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: who is acked this cycle follows from who won arbitration last cycle.
  bit          mon_en   = 1'b0;
  int          exp_own  = -1;
  int          last_win = 1;
  int          win;
  logic [10:0] exp_addr = '0;
  bit          e0, e1;
  logic        prev_req0, prev_req1, prev_ack0, prev_ack1;
  logic        prev_rst = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!reset) begin
        chk("rst_m0_ack", 32'(bus.m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(bus.m1_ack), 32'd0);
        exp_own  = -1;
        last_win = 1;
      end else begin
        chk("m0_ack", 32'(bus.m0_ack), 32'(exp_own == 0));
        chk("m1_ack", 32'(bus.m1_ack), 32'(exp_own == 1));
        chk("ack_excl", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
        if (exp_own == 0) chk("m0_data", bus.m0_rd_data, 32'hA500_0000 + 32'(exp_addr));
        if (exp_own == 1) chk("m1_data", bus.m1_rd_data, 32'hA500_0000 + 32'(exp_addr));
        if (prev_rst) begin
          chk("proto_hold0", 32'(prev_req0 && !prev_ack0 && !bus.m0_req), 32'd0);
          chk("proto_hold1", 32'(prev_req1 && !prev_ack1 && !bus.m1_req), 32'd0);
        end
        e0 = bus.m0_req && (exp_own != 0);
        e1 = bus.m1_req && (exp_own != 1);
        if (e0 && e1)  win = (last_win == 0) ? 1 : 0;
        else if (e0)   win = 0;
        else if (e1)   win = 1;
        else           win = -1;
        if (win >= 0) begin
          exp_addr = (win == 0) ? bus.m0_addr : bus.m1_addr;
          chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
          last_win = win;
        end
        exp_own = win;
      end
    end
    prev_req0 = bus.m0_req;
    prev_req1 = bus.m1_req;
    prev_ack0 = bus.m0_ack;
    prev_ack1 = bus.m1_ack;
    prev_rst  = reset;
  end

  // Master drivers: cnt = reads still wanted; amode 0 hold, 1 increment, 2 random address
  int          cnt     [2];
  int          amode   [2];
  logic        mreq    [2];
  logic [10:0] maddr   [2];
  logic        cur_ack [2];
  logic [31:0] sexp    [4] = '{32'hA500_07FE, 32'hA500_07FF, 32'hA500_0000, 32'hA500_0001};

  task automatic apply();
    bus.m0_req  = mreq[0];
    bus.m1_req  = mreq[1];
    bus.m0_addr = maddr[0];
    bus.m1_addr = maddr[1];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (mreq[i] && cur_ack[i]) begin
        cnt[i]--;
        if (amode[i] == 1)      maddr[i] = maddr[i] + 11'd1;
        else if (amode[i] == 2) maddr[i] = 11'($urandom);
      end
      mreq[i] = (cnt[i] > 0);
    end
    apply();
    cur_ack[0] = bus.m0_ack;
    cur_ack[1] = bus.m1_ack;
  endtask

  initial begin
    reset   = 1'b1;
    cnt     = '{0, 0};
    amode   = '{0, 0};
    mreq    = '{1'b0, 1'b0};
    cur_ack = '{1'b0, 1'b0};
    maddr   = '{11'h005, 11'h006};
    apply();
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // reset held with both masters requesting
    cnt  = '{1, 1};
    mreq = '{1'b1, 1'b1};
    apply();
    repeat (3) begin
      step();
      chk("rsthold_m0_ack", 32'(bus.m0_ack), 32'd0);
      chk("rsthold_m1_ack", 32'(bus.m1_ack), 32'd0);
    end
    reset = 1'b1;
    step();
    chk("first_ack_m0", 32'(bus.m0_ack), 32'd1);
    chk("first_ack_not_m1", 32'(bus.m1_ack), 32'd0);
    chk("first_data", bus.m0_rd_data, 32'hA500_0005);
    step();
    chk("second_ack_m1", 32'(bus.m1_ack), 32'd1);
    chk("second_data", bus.m1_rd_data, 32'hA500_0006);
    repeat (2) step();

    // single M0 read
    maddr[0] = 11'h010;
    cnt[0]   = 1;
    step();
    chk("single_wait", 32'(bus.m0_ack), 32'd0);
    step();
    chk("single_ack", 32'(bus.m0_ack), 32'd1);
    chk("single_data", bus.m0_rd_data, 32'hA500_0010);
    chk("single_m1_quiet", 32'(bus.m1_ack), 32'd0);
    repeat (2) step();

    // M1 streaming across the top of the address space
    maddr[1] = 11'h7FE;
    amode[1] = 1;
    cnt[1]   = 4;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("stream_ack", 32'(bus.m1_ack), 32'((k % 2) == 0));
      if ((k % 2) == 0) chk("stream_data", bus.m1_rd_data, sexp[k/2]);
    end
    amode[1] = 0;
    repeat (2) step();

    // contention: strict alternation starting with M0
    maddr = '{11'h001, 11'h002};
    cnt   = '{4, 4};
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("cont_m0_ack", 32'(bus.m0_ack), 32'((k % 2) == 0));
      chk("cont_m1_ack", 32'(bus.m1_ack), 32'((k % 2) == 1));
      if ((k % 2) == 0) chk("cont_m0_data", bus.m0_rd_data, 32'hA500_0001);
      else              chk("cont_m1_data", bus.m1_rd_data, 32'hA500_0002);
    end
    repeat (2) step();

    // late arrival: M0 raises req during M1's ack cycle
    maddr[1] = 11'h123;
    cnt[1]   = 1;
    step();
    step();
    chk("late_m1_ack", 32'(bus.m1_ack), 32'd1);
    maddr[0] = 11'h456;
    cnt[0]   = 1;
    mreq[0]  = 1'b1;
    apply();
    step();
    chk("late_m0_ack", 32'(bus.m0_ack), 32'd1);
    chk("late_m0_data", bus.m0_rd_data, 32'hA500_0456);
    repeat (2) step();

    // reset during M1's READ cycle
    maddr[1] = 11'h200;
    cnt[1]   = 1;
    step();
    step();
    chk("midrd_m1_ack", 32'(bus.m1_ack), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrd_async_drop", 32'(bus.m1_ack), 32'd0);
    cur_ack[1] = 1'b0;
    maddr[0]   = 11'h300;
    cnt[0]     = 1;
    mreq[0]    = 1'b1;
    apply();
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("midrd_m0_first", 32'(bus.m0_ack), 32'd1);
    chk("midrd_m0_data", bus.m0_rd_data, 32'hA500_0300);
    step();
    chk("midrd_m1_reissue", 32'(bus.m1_ack), 32'd1);
    chk("midrd_m1_data", bus.m1_rd_data, 32'hA500_0200);
    repeat (2) step();

    // random traffic, checked by the reference model
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (cnt[i] == 0 && $urandom_range(0, 2) == 0) begin
          cnt[i]   = int'($urandom_range(1, 4));
          amode[i] = int'($urandom_range(0, 2));
          maddr[i] = 11'($urandom);
        end
      end
      step();
    end
    for (int k = 0; k < 40 && (cnt[0] + cnt[1]) != 0; k++) step();
    chk("drain", 32'(cnt[0] + cnt[1]), 32'd0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
